// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the single-issue MIPS core: sequences fetch, decode,
// execute, memory and writeback over the shared datapath and one req/ack memory port.
module mc_ctrl #(
    parameter bit          ILLEGAL_HALT = 1'b1,
    parameter int unsigned MEM_TIMEOUT  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] npc_sel,
    output logic [1:0] extop,
    output logic       alu_b_sel,
    output logic [2:0] alu_op,
    output logic       reg_we,
    output logic       reg_dst,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic       timeout,
    output logic [2:0] state
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;
    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DCD = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_ORI, C_ADDIU, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_ILL
    } cls_e;

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d, dec_cls, cls_c;
    logic             illegal_q, illegal_d, timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       mem_req_c, mem_we_c, iord_c, ir_we_c, pc_we_c;
    logic       alu_b_sel_c, reg_we_c, reg_dst_c;
    logic [1:0] npc_sel_c, extop_c, wb_sel_c;
    logic [2:0] alu_op_c;

    function automatic logic [1:0] ext_of(input cls_e c);
        case (c)
            C_ADDIU, C_LW, C_SW, C_BEQ: return EXT_SIGN;
            C_LUI:                      return EXT_UPPER;
            default:                    return EXT_ZERO;
        endcase
    endfunction

    // Instruction class straight from the IR fields
    always_comb begin
        dec_cls = C_ILL;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU)      dec_cls = C_ADDU;
                else if (funct == FN_SUBU) dec_cls = C_SUBU;
            end
            OP_ORI:   dec_cls = C_ORI;
            OP_ADDIU: dec_cls = C_ADDIU;
            OP_LUI:   dec_cls = C_LUI;
            OP_LW:    dec_cls = C_LW;
            OP_SW:    dec_cls = C_SW;
            OP_BEQ:   dec_cls = C_BEQ;
            OP_J:     dec_cls = C_J;
            default:  dec_cls = C_ILL;
        endcase
    end

    // The class register is only loaded at the end of DCD, so DCD uses the live decode
    assign cls_c = (state_q == S_DCD) ? dec_cls : cls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ILL;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        iord_c      = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        npc_sel_c   = NPC_SEQ;
        extop_c     = EXT_ZERO;
        alu_b_sel_c = 1'b0;
        alu_op_c    = ALU_ADD;
        reg_we_c    = 1'b0;
        reg_dst_c   = 1'b0;
        wb_sel_c    = WB_ALU;

        if (state_q inside {S_DCD, S_EXE, S_MEM, S_WB}) extop_c = ext_of(cls_c);

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                ir_we_c   = mem_ack;
                pc_we_c   = mem_ack;
                if (mem_ack) state_d = S_DCD;
            end
            S_DCD: begin
                cls_d = dec_cls;
                case (dec_cls)
                    C_J: begin
                        pc_we_c   = 1'b1;
                        npc_sel_c = NPC_JMP;
                        state_d   = S_FETCH;
                    end
                    C_ILL: begin
                        illegal_d = 1'b1;
                        state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                state_d = S_WB;
                case (cls_q)
                    C_ADDU: alu_op_c = ALU_ADD;
                    C_SUBU: alu_op_c = ALU_SUB;
                    C_ORI: begin
                        alu_b_sel_c = 1'b1;
                        alu_op_c    = ALU_OR;
                    end
                    C_ADDIU: alu_b_sel_c = 1'b1;
                    C_LW, C_SW: begin
                        alu_b_sel_c = 1'b1;
                        state_d     = S_MEM;
                    end
                    C_BEQ: begin
                        alu_op_c  = ALU_SUB;
                        pc_we_c   = zero;
                        npc_sel_c = NPC_BR;
                        state_d   = S_FETCH;
                    end
                    C_LUI:   state_d = S_WB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                mem_we_c  = (cls_q == C_SW);
                if (mem_ack) state_d = (cls_q == C_SW) ? S_FETCH : S_WB;
            end
            S_WB: begin
                reg_we_c  = 1'b1;
                reg_dst_c = (cls_q == C_ADDU) || (cls_q == C_SUBU);
                if (cls_q == C_LW)       wb_sel_c = WB_MEM;
                else if (cls_q == C_LUI) wb_sel_c = WB_IMM;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Wait-cycle watchdog; an ack in the limit cycle still completes the access
        if (MEM_TIMEOUT != 0 && mem_req_c) begin
            if (mem_ack) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                cnt_d     = CNT_W'(MEM_TIMEOUT);
                timeout_d = 1'b1;
                state_d   = S_HALT;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Reset forces every output low in the same cycle
    assign mem_req   = mem_req_c & ~rst;
    assign mem_we    = mem_we_c & ~rst;
    assign iord      = iord_c & ~rst;
    assign ir_we     = ir_we_c & ~rst;
    assign pc_we     = pc_we_c & ~rst;
    assign npc_sel   = rst ? 2'b00 : npc_sel_c;
    assign extop     = rst ? 2'b00 : extop_c;
    assign alu_b_sel = alu_b_sel_c & ~rst;
    assign alu_op    = rst ? 3'b000 : alu_op_c;
    assign reg_we    = reg_we_c & ~rst;
    assign reg_dst   = reg_dst_c & ~rst;
    assign wb_sel    = rst ? 2'b00 : wb_sel_c;
    assign illegal   = illegal_q & ~rst;
    assign timeout   = timeout_q & ~rst;
    assign state     = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction scoreboard against a behavioural instruction model,
// plus directed halt, timeout and reset-during-access sequences.
module tb_mc_ctrl;

    logic       clk, rst, zero, mem_ack;
    logic [5:0] op, funct;
    logic       mem_req, mem_we, iord, ir_we, pc_we, alu_b_sel, reg_we, reg_dst, illegal, timeout;
    logic [1:0] npc_sel, extop, wb_sel;
    logic [2:0] alu_op, state;

    mc_ctrl #(.ILLEGAL_HALT(1'b1), .MEM_TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
        .npc_sel(npc_sel), .extop(extop), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
        .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel), .illegal(illegal),
        .timeout(timeout), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] sig;
        int          ncyc;
        int          n_pc_we;
        logic [1:0]  br_sel;
        int          n_reg_we;
        logic        rdst;
        logic [1:0]  wbs;
        logic [1:0]  ext;
        logic        chk_op;
        logic [2:0]  aop;
        logic        chk_b;
        logic        ab;
        int          n_mem_we;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    logic [5:0] op_tab[10] = '{6'h00, 6'h00, 6'h0D, 6'h09, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h04, 6'h02};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // What one instruction should look like, from the instruction-level rules
    function automatic exp_t model(input logic [5:0] o, input logic [5:0] f, input logic z,
                                   input int fw, input int mw);
        exp_t e;
        int   path[$];
        bit   is_r, is_ori, is_addiu, is_lui, is_lw, is_sw, is_beq, is_j, legal;
        is_r     = (o == 6'h00) && (f == 6'h21 || f == 6'h23);
        is_ori   = (o == 6'h0D);
        is_addiu = (o == 6'h09);
        is_lui   = (o == 6'h0F);
        is_lw    = (o == 6'h23);
        is_sw    = (o == 6'h2B);
        is_beq   = (o == 6'h04);
        is_j     = (o == 6'h02);
        legal    = is_r | is_ori | is_addiu | is_lui | is_lw | is_sw | is_beq | is_j;
        for (int i = 0; i <= fw; i++) path.push_back(0);
        path.push_back(1);
        if (legal && !is_j) begin
            path.push_back(2);
            if (is_lw || is_sw) for (int i = 0; i <= mw; i++) path.push_back(3);
            if (!is_beq && !is_sw) path.push_back(4);
        end
        e.sig = '0;
        foreach (path[i]) e.sig = (e.sig << 3) | 64'(path[i] + 1);
        e.ncyc     = path.size();
        e.n_pc_we  = 1 + ((is_j || (is_beq && z)) ? 1 : 0);
        e.br_sel   = is_j ? 2'd2 : (is_beq && z) ? 2'd1 : 2'd0;
        e.n_reg_we = (is_r | is_ori | is_addiu | is_lui | is_lw) ? 1 : 0;
        e.rdst     = is_r;
        e.wbs      = is_lw ? 2'd1 : is_lui ? 2'd2 : 2'd0;
        e.ext      = is_lui ? 2'd2 : (is_addiu | is_lw | is_sw | is_beq) ? 2'd1 : 2'd0;
        e.chk_op   = !is_lui;
        e.chk_b    = !is_lui && !is_beq;
        e.aop      = (is_r && f == 6'h23) || is_beq ? 3'd1 : is_ori ? 3'd2 : 3'd0;
        e.ab       = is_ori | is_addiu | is_lw | is_sw;
        e.n_mem_we = is_sw ? mw + 1 : 0;
        e.ill      = !legal;
        return e;
    endfunction

    // Drive one instruction and act as the memory, starting in its FETCH cycle
    task automatic run_txn(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fw, input int mw);
        int fc = 0, mc = 0, n = 0;
        bit left = 1'b0;
        exp_q.push_back(model(o, f, z, fw, mw));
        op = o;
        funct = f;
        zero = z;
        forever begin
            if (mem_req) begin
                if (!iord) begin
                    mem_ack = (fc == fw);
                    fc++;
                end else begin
                    mem_ack = (mc == mw);
                    mc++;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
            if (state != 3'd0) left = 1'b1;
            if ((left && state == 3'd0) || state == 3'd5) break;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL txn_bound: got %0d cycles want <=100", n);
                break;
            end
        end
        mem_ack = 1'b0;
    endtask

    logic [63:0] m_sig;
    int          m_ncyc, m_pc, m_reg, m_mw, m_ir, m_viol;
    logic [1:0]  m_br, m_fsel, m_wbs, m_ext;
    logic        m_rdst, m_ab;
    logic [2:0]  m_aop, m_prev;

    task automatic mon_clear();
        m_sig = '0; m_ncyc = 0; m_pc = 0; m_reg = 0; m_mw = 0; m_ir = 0; m_viol = 0;
        m_br = '0; m_fsel = '0; m_wbs = '0; m_ext = '0; m_rdst = 1'b0; m_ab = 1'b0; m_aop = '0;
    endtask

    // Monitor: closes an instruction whenever the FSM re-enters FETCH or enters HALT
    initial begin
        exp_t e;
        m_prev = 3'd0;
        mon_clear();
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                mon_clear();
                m_prev = 3'd0;
            end else begin
                if ((state == 3'd0 && m_prev != 3'd0) || (state == 3'd5 && m_prev != 3'd5)) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_underflow: got 0 entries want >=1");
                    end else begin
                        e = exp_q.pop_front();
                        check("cycles", 64'(m_ncyc), 64'(e.ncyc));
                        check("state_seq", m_sig, e.sig);
                        check("pc_we_n", 64'(m_pc), 64'(e.n_pc_we));
                        check("npc_sel", 64'(m_br), 64'(e.br_sel));
                        check("fetch_npc", 64'(m_fsel), 64'(0));
                        check("reg_we_n", 64'(m_reg), 64'(e.n_reg_we));
                        check("reg_dst", 64'(m_rdst), 64'(e.rdst));
                        check("wb_sel", 64'(m_wbs), 64'(e.wbs));
                        check("extop", 64'(m_ext), 64'(e.ext));
                        if (e.chk_op) check("alu_op", 64'(m_aop), 64'(e.aop));
                        if (e.chk_b) check("alu_b_sel", 64'(m_ab), 64'(e.ab));
                        check("mem_we_n", 64'(m_mw), 64'(e.n_mem_we));
                        check("ir_we_n", 64'(m_ir), 64'(1));
                        check("rules", 64'(m_viol), 64'(0));
                        check("illegal", 64'(illegal), 64'(e.ill));
                    end
                    mon_clear();
                end
                if (state != 3'd5) begin
                    m_sig = (m_sig << 3) | 64'(state + 3'd1);
                    m_ncyc++;
                    if (pc_we) begin
                        m_pc++;
                        if (state == 3'd0) m_fsel = npc_sel;
                        else m_br = npc_sel;
                    end
                    if (reg_we) begin
                        m_reg++;
                        m_rdst = reg_dst;
                        m_wbs = wb_sel;
                    end
                    if (ir_we) m_ir++;
                    if (state == 3'd1) m_ext = extop;
                    if (state >= 3'd1 && state <= 3'd4 && extop != m_ext) m_viol++;
                    if (state == 3'd2) begin
                        m_aop = alu_op;
                        m_ab = alu_b_sel;
                    end
                    if (mem_we) m_mw++;
                    if (mem_we && !mem_req) m_viol++;
                    if (pc_we && reg_we) m_viol++;
                    if (ir_we && state != 3'd0) m_viol++;
                end
                m_prev = state;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ack = 1'b1;
        #1;
        check("rst_state_pre", 64'(state), 64'(0));
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_ir_we", 64'(ir_we), 64'(0));
        tick();
        tick();
        check("rst_illegal", 64'(illegal), 64'(0));
        rst = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("post_rst_state", 64'(state), 64'(0));
        check("post_rst_req", 64'(mem_req), 64'(1));
        check("post_rst_timeout", 64'(timeout), 64'(0));

        mon_en = 1'b1;
        run_txn(6'h00, 6'h21, 1'b0, 0, 0);   // addu
        run_txn(6'h23, 6'h00, 1'b0, 3, 3);   // lw, 3 wait cycles each access
        run_txn(6'h0F, 6'h00, 1'b0, 0, 0);   // lui
        run_txn(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
        run_txn(6'h04, 6'h00, 1'b0, 1, 0);   // beq not taken
        run_txn(6'h02, 6'h00, 1'b0, 0, 0);   // j
        run_txn(6'h2B, 6'h00, 1'b0, 2, 1);   // sw
        for (int i = 0; i < 60; i++) begin
            int k = $urandom_range(0, 9);
            logic [5:0] f = (k == 0) ? 6'h21 : (k == 1) ? 6'h23 : 6'($urandom_range(0, 63));
            run_txn(op_tab[k], f, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run_txn(6'h3F, 6'h00, 1'b0, 0, 0);   // illegal -> HALT
        repeat (3) tick();
        check("sb_drained", 64'(exp_q.size()), 64'(0));
        mon_en = 1'b0;

        for (int i = 0; i < 20; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            tick();
            check("halt_strobes", 64'({mem_req, mem_we, ir_we, pc_we, reg_we}), 64'(0));
        end
        check("halt_state", 64'(state), 64'(5));
        check("halt_illegal", 64'(illegal), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("unhalt_state", 64'(state), 64'(0));
        check("unhalt_illegal", 64'(illegal), 64'(0));

        // Timeout: no ack during fetch
        repeat (3) tick();
        check("to_pre_state", 64'(state), 64'(0));
        check("to_pre_flag", 64'(timeout), 64'(0));
        tick();
        check("to_state", 64'(state), 64'(5));
        check("to_flag", 64'(timeout), 64'(1));
        check("to_req_drop", 64'(mem_req), 64'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        mem_ack = 1'b1;
        tick();
        check("to_ack_state", 64'(state), 64'(1));
        check("to_ack_flag", 64'(timeout), 64'(0));

        // Reset in the middle of a store wait
        rst = 1'b1;
        mem_ack = 1'b0;
        op = 6'h2B;
        tick();
        rst = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
        check("sw_mem_state", 64'(state), 64'(3));
        check("sw_mem_we", 64'({mem_req, mem_we, iord}), 64'(7));
        tick();
        rst = 1'b1;
        mem_ack = 1'b1;
        #1;
        check("rst_mid_req", 64'({mem_req, mem_we}), 64'(0));
        tick();
        rst = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("rst_mid_state", 64'(state), 64'(0));
        tick();
        check("stale_ack_state", 64'(state), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM for the single-issue MIPS core.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over the shared datapath: PC, IR, register file, ALU, immediate extender and one unified memory port.
- Drives the extender's 2-bit extop (00 zero-ext, 01 sign-ext, 10 to upper half) and all datapath write strobes and selects.
- Uses a req/ack handshake to the memory port.

Parameters:
- ILLEGAL_HALT, 1: 1 = illegal opcode enters HALT; 0 = illegal opcode is executed as a NOP.
- MEM_TIMEOUT, 0: maximum wait cycles for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26], valid while the FSM is not in FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ack  in  1  memory transfer complete; sampled only while mem_req=1
- mem_req  out  1  memory access request
- mem_we  out  1  store strobe, qualified by mem_req
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- ir_we  out  1  IR load
- pc_we  out  1  PC load
- npc_sel  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target
- extop  out  2  immediate extender control
- alu_b_sel  out  1  ALU B input: 0 = rt, 1 = imm32
- alu_op  out  3  000 = add, 001 = sub, 010 = or
- reg_we  out  1  register file write
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- wb_sel  out  2  writeback source: 00 = ALU, 01 = memory data, 10 = imm32
- illegal  out  1  sticky illegal-instruction flag
- timeout  out  1  sticky memory-timeout flag
- state  out  3  current state, for debug

Behaviour:
- State encoding: FETCH = 0, DCD = 1, EXE = 2, MEM = 3, WB = 4, HALT = 5.
- Supported instructions:
  - addu (op 0, funct 21h), subu (op 0, funct 23h)
  - ori 0Dh, addiu 09h, lui 0Fh
  - lw 23h, sw 2Bh, beq 04h, j 02h
  - Anything else is illegal.
- Outputs are decoded combinationally from state plus a latched opcode class. Every output is 0 while rst=1.
- Reset: on the next clk edge with rst=1, state <= FETCH, illegal <= 0, timeout <= 0, wait counter <= 0. Reset asserted mid-access drops mem_req immediately with no further strobes; any pending ack is ignored.
- FETCH:
  - mem_req=1, iord=0, ir_we=mem_ack, pc_we=mem_ack, npc_sel=00.
  - Stays in FETCH until mem_ack=1, then goes to DCD.
- DCD:
  - Latches op/funct into the class register.
  - extop is valid from DCD through WB: ori gives 00; addiu/lw/sw/beq give 01; lui gives 10; others 00.
  - j: pc_we=1, npc_sel=10, next state FETCH.
  - Legal non-j instructions go to EXE.
  - Illegal: if ILLEGAL_HALT=1, go to HALT and set illegal; otherwise go to FETCH and set illegal.
- EXE:
  - R-type: alu_b_sel=0, alu_op add/sub.
  - ori: alu_b_sel=1, alu_op or.
  - addiu/lw/sw: alu_b_sel=1, alu_op add.
  - beq: alu_op sub, pc_we=zero, npc_sel=01, next state FETCH.
  - lui goes directly to WB (ALU unused).
  - lw/sw go to MEM; all other instructions go to WB.
- MEM:
  - mem_req=1, iord=1, mem_we=(sw).
  - Waits for mem_ack, then sw goes to FETCH and lw goes to WB.
- WB:
  - reg_we=1; reg_dst=1 for R-type, 0 otherwise.
  - wb_sel: lw = 01, lui = 10, others = 00.
  - Next state FETCH.
- HALT: all strobes 0; stays in HALT until rst.
- Cycle counts with zero-wait memory (mem_ack in the first request cycle):
  - j: 2
  - beq: 3
  - R-type, ori, addiu, lui, sw: 4
  - lw: 5
  - Each wait cycle adds 1.
- Timeout: with MEM_TIMEOUT=N>0, the wait counter increments on every cycle with mem_req=1 and mem_ack=0, and clears on ack.
  - When the counter reaches N: timeout <= 1, next state HALT, mem_req deasserted the following cycle.
  - An ack arriving in the same cycle the counter reaches N takes priority (the access completes).
- mem_ack while mem_req=0: ignored, no state change.
- pc_we and reg_we never assert in the same cycle. ir_we asserts only in FETCH.

Test Plan:
- Reset then addu (op 0, funct 21h), mem_ack tied 1 -> states 0,1,2,4,0; reg_we=1 and reg_dst=1 only in WB; pc_we=1 only in FETCH.
- lw with mem_ack delayed 3 cycles in both FETCH and MEM -> 11 cycles total; mem_req held high throughout each wait; wb_sel=01 in WB; extop=01 from DCD onward.
- lui 0Fh -> extop=10, wb_sel=10, no MEM state; then beq with zero=1 -> pc_we=1 and npc_sel=01 in EXE; with zero=0 -> pc_we=0.
- op 3Fh with ILLEGAL_HALT=1 -> HALT, illegal=1, no strobes for 20 cycles; rst=1 for one edge -> FETCH, illegal=0.
- MEM_TIMEOUT=4, mem_ack never asserts in FETCH -> timeout=1 and state=HALT on the 4th wait edge; rerun with ack in that same cycle -> state DCD, timeout=0.
- rst asserted during a MEM wait of sw -> mem_req=0 and mem_we=0 immediately; next state FETCH; a stale mem_ack one cycle after reset does not advance the FSM until the new fetch is requested.
